// File: rtl/lcd_tile_renderer.sv
// Streams one raster frame of a COLS x ROWS grid of solid-colour tiles to LT24Display.
// Tile hits are tracked with in-tile offset and tile-index counters that advance with the raster.
module lcd_tile_renderer #(
   parameter int unsigned WIDTH     = 240,
   parameter int unsigned HEIGHT    = 320,
   parameter int unsigned COLS      = 4,
   parameter int unsigned ROWS      = 4,
   parameter int unsigned TILE_W    = 48,
   parameter int unsigned TILE_H    = 64,
   parameter int unsigned GAP       = 8,
   parameter int unsigned X0        = 12,
   parameter int unsigned Y0        = 20,
   parameter logic [15:0] BG_COLOUR = 16'h0000,
   localparam int unsigned TA       = $clog2(COLS * ROWS),
   localparam int unsigned XW       = $clog2(WIDTH),
   localparam int unsigned YW       = $clog2(HEIGHT)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          frameDone,
   input  logic          tileWrite,
   input  logic [TA-1:0] tileAddr,
   input  logic [15:0]   tileColour,
   input  logic          highlightEn,
   input  logic [TA-1:0] highlightIdx,
   output logic [XW-1:0] xAddr,
   output logic [YW-1:0] yAddr,
   output logic [15:0]   pixelData,
   output logic          pixelWrite,
   input  logic          pixelReady
);

   localparam int unsigned NumTiles = COLS * ROWS;
   localparam int unsigned PeriodX  = TILE_W + GAP;
   localparam int unsigned PeriodY  = TILE_H + GAP;
   localparam int unsigned OXW      = $clog2(PeriodX);
   localparam int unsigned OYW      = $clog2(PeriodY);
   localparam int unsigned CW       = $clog2(COLS + 1);
   localparam int unsigned RW       = $clog2(ROWS + 1);

   if (X0 + COLS * TILE_W + (COLS - 1) * GAP > WIDTH) begin : g_bad_x
      $error("tile grid does not fit in WIDTH");
   end
   if (Y0 + ROWS * TILE_H + (ROWS - 1) * GAP > HEIGHT) begin : g_bad_y
      $error("tile grid does not fit in HEIGHT");
   end

   typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;
   state_e state_q;

   logic [15:0] tile_q [NumTiles];
   logic        addr_ok;

   // Tracker state describes the pixel currently held in the output registers.
   logic           x_act_q, y_act_q;
   logic [OXW-1:0] x_off_q;
   logic [OYW-1:0] y_off_q;
   logic [CW-1:0]  x_col_q;
   logic [RW-1:0]  y_row_q;

   logic           x_act_d, y_act_d;
   logic [OXW-1:0] x_off_d;
   logic [OYW-1:0] y_off_d;
   logic [CW-1:0]  x_col_d;
   logic [RW-1:0]  y_row_d;
   logic [XW-1:0]  x_d;
   logic [YW-1:0]  y_d;
   logic [15:0]    pix_d;
   logic [15:0]    colour;
   logic [TA-1:0]  tile_idx;
   logic           first, x_wrap, y_last, hit, load;

   if (NumTiles == (1 << TA)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (32'(tileAddr) < NumTiles);
   end

   always_comb begin
      first  = (state_q == StIdle);
      x_wrap = (xAddr == XW'(WIDTH - 1));
      y_last = (yAddr == YW'(HEIGHT - 1));

      x_d     = '0;
      x_act_d = (X0 == 0);
      x_off_d = '0;
      x_col_d = '0;
      if (!first && !x_wrap) begin
         x_d     = xAddr + XW'(1);
         x_act_d = x_act_q;
         x_off_d = x_off_q;
         x_col_d = x_col_q;
         if (x_d == XW'(X0)) begin
            x_act_d = 1'b1;
            x_off_d = '0;
            x_col_d = '0;
         end else if (x_act_q) begin
            if (x_off_q == OXW'(PeriodX - 1)) begin
               x_off_d = '0;
               if (x_col_q != CW'(COLS)) x_col_d = x_col_q + CW'(1);
            end else begin
               x_off_d = x_off_q + OXW'(1);
            end
         end
      end

      y_d     = yAddr;
      y_act_d = y_act_q;
      y_off_d = y_off_q;
      y_row_d = y_row_q;
      if (first) begin
         y_d     = '0;
         y_act_d = (Y0 == 0);
         y_off_d = '0;
         y_row_d = '0;
      end else if (x_wrap) begin
         y_d = yAddr + YW'(1);
         if (y_d == YW'(Y0)) begin
            y_act_d = 1'b1;
            y_off_d = '0;
            y_row_d = '0;
         end else if (y_act_q) begin
            if (y_off_q == OYW'(PeriodY - 1)) begin
               y_off_d = '0;
               if (y_row_q != RW'(ROWS)) y_row_d = y_row_q + RW'(1);
            end else begin
               y_off_d = y_off_q + OYW'(1);
            end
         end
      end

      hit = x_act_d && y_act_d && (x_col_d < CW'(COLS)) && (y_row_d < RW'(ROWS)) &&
            (x_off_d < OXW'(TILE_W)) && (y_off_d < OYW'(TILE_H));
      tile_idx = TA'(32'(y_row_d) * COLS + 32'(x_col_d));
      colour   = tile_q[tile_idx];
      if (highlightEn && (tile_idx == highlightIdx)) colour = ~colour;
      pix_d = hit ? colour : BG_COLOUR;

      load = (first && start) ||
             ((state_q == StDraw) && pixelWrite && pixelReady && !(x_wrap && y_last));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NumTiles); i++) tile_q[i] <= '0;
      end else if (tileWrite && addr_ok) begin
         tile_q[tileAddr] <= tileColour;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         busy       <= 1'b0;
         frameDone  <= 1'b0;
         pixelWrite <= 1'b0;
         xAddr      <= '0;
         yAddr      <= '0;
         pixelData  <= '0;
         x_act_q    <= 1'b0;
         x_off_q    <= '0;
         x_col_q    <= '0;
         y_act_q    <= 1'b0;
         y_off_q    <= '0;
         y_row_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               frameDone <= 1'b0;
               if (start) begin
                  state_q    <= StDraw;
                  busy       <= 1'b1;
                  pixelWrite <= 1'b1;
               end
            end
            StDraw: begin
               if (pixelWrite && pixelReady && x_wrap && y_last) begin
                  state_q    <= StDone;
                  busy       <= 1'b0;
                  pixelWrite <= 1'b0;
                  frameDone  <= 1'b1;
               end
            end
            StDone: begin
               frameDone <= 1'b0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
         if (load) begin
            xAddr     <= x_d;
            yAddr     <= y_d;
            pixelData <= pix_d;
            x_act_q   <= x_act_d;
            x_off_q   <= x_off_d;
            x_col_q   <= x_col_d;
            y_act_q   <= y_act_d;
            y_off_q   <= y_off_d;
            y_row_q   <= y_row_d;
         end
      end
   end

endmodule

// File: tb/tb_lcd_tile_renderer.sv
// Directed bench for lcd_tile_renderer on a reduced 22x17 frame with a 3x3 tile grid.
`timescale 1ns/1ps
module tb_lcd_tile_renderer;

   localparam int W  = 22;
   localparam int H  = 17;
   localparam int C  = 3;
   localparam int R  = 3;
   localparam int TW = 4;
   localparam int TH = 3;
   localparam int G  = 2;
   localparam int XO = 3;
   localparam int YO = 2;
   localparam logic [15:0] BG = 16'h5AA5;
   localparam int NPIX = W * H;
   localparam int TA = $clog2(C * R);
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          tileWrite = 1'b0;
   logic [TA-1:0] tileAddr = '0;
   logic [15:0]   tileColour = '0;
   logic          highlightEn = 1'b0;
   logic [TA-1:0] highlightIdx = '0;
   logic          pixelReady = 1'b1;
   logic          busy, frameDone, pixelWrite;
   logic [XW-1:0] xAddr;
   logic [YW-1:0] yAddr;
   logic [15:0]   pixelData;

   int checks = 0;
   int errors = 0;

   lcd_tile_renderer #(
      .WIDTH(W), .HEIGHT(H), .COLS(C), .ROWS(R), .TILE_W(TW), .TILE_H(TH), .GAP(G),
      .X0(XO), .Y0(YO), .BG_COLOUR(BG)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .frameDone(frameDone),
      .tileWrite(tileWrite), .tileAddr(tileAddr), .tileColour(tileColour),
      .highlightEn(highlightEn), .highlightIdx(highlightIdx), .xAddr(xAddr), .yAddr(yAddr),
      .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady)
   );

   always #5 clock = ~clock;

   // Negedge recorder of accepted pixels, frameDone timing and stall hold behaviour.
   int ncyc = 0, acc_cnt = 0, done_cnt = 0, done_lag = 0, hold_viol = 0, last_acc = 0;
   logic [XW-1:0] seq_x [NPIX];
   logic [YW-1:0] seq_y [NPIX];
   logic [15:0]   seq_d [NPIX];
   logic          stall_prev = 1'b0;
   logic [XW-1:0] hx;
   logic [YW-1:0] hy;
   logic [15:0]   hd;

   always @(negedge clock) begin
      ncyc++;
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (start && !busy && !frameDone) begin
            acc_cnt = 0; done_cnt = 0; hold_viol = 0;
         end
         if (stall_prev && (!pixelWrite || xAddr !== hx || yAddr !== hy || pixelData !== hd))
            hold_viol++;
         stall_prev = pixelWrite && !pixelReady;
         hx = xAddr; hy = yAddr; hd = pixelData;
         if (frameDone) begin
            if (done_cnt == 0) done_lag = ncyc - last_acc;
            done_cnt++;
         end
         if (pixelWrite && pixelReady) begin
            if (acc_cnt < NPIX) begin
               seq_x[acc_cnt] = xAddr; seq_y[acc_cnt] = yAddr; seq_d[acc_cnt] = pixelData;
            end
            acc_cnt++;
            if (int'(xAddr) == W - 1 && int'(yAddr) == H - 1) last_acc = ncyc;
         end
      end
   end

   logic [15:0] mdl [C*R];

   function automatic logic [15:0] ref_pix(int x, int y);
      int dx, dy, c, r;
      dx = x - XO; dy = y - YO;
      if (dx < 0 || dy < 0) return BG;
      c = dx / (TW + G); r = dy / (TH + G);
      if (c >= C || r >= R || dx % (TW + G) >= TW || dy % (TH + G) >= TH) return BG;
      if (highlightEn && (r * C + c) == int'(highlightIdx)) return ~mdl[r * C + c];
      return mdl[r * C + c];
   endfunction

   function automatic logic [31:0] px(int x, int y);
      return 32'(seq_d[y * W + x]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic write_tile(input int addr, input logic [15:0] col);
      @(posedge clock); #1;
      tileWrite = 1'b1; tileAddr = TA'(addr); tileColour = col;
      @(posedge clock); #1;
      tileWrite = 1'b0;
      if (addr < C * R) mdl[addr] = col;
   endtask

   task automatic start_frame();
      @(posedge clock); #1; start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
   endtask

   task automatic run_frame(input bit stall, input int wx, input int wy, input int waddr,
                            input logic [15:0] wcol);
      bit done = 1'b0;
      bit wrote = 1'b0;
      int cyc = 0;
      while (!done && cyc < 5000) begin
         @(posedge clock); #1;
         cyc++;
         tileWrite = 1'b0;
         if (frameDone) begin
            done = 1'b1;
            chk("done_busy", 32'(busy), 0);
            chk("done_pixelWrite", 32'(pixelWrite), 0);
         end else begin
            if (stall) begin
               pixelReady = ($urandom_range(0, 1) == 1);
               start = busy && ($urandom_range(0, 7) == 0);
            end
            if (wx >= 0 && !wrote && int'(xAddr) == wx && int'(yAddr) == wy) begin
               tileWrite = 1'b1; tileAddr = TA'(waddr); tileColour = wcol; wrote = 1'b1;
            end
         end
      end
      pixelReady = 1'b1; start = 1'b0;
      chk("frame_timeout", 32'(done), 1);
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic check_frame(input string tag, input int skip);
      int bad = 0;
      for (int i = 0; i < NPIX; i++) begin
         if (int'(seq_x[i]) != i % W || int'(seq_y[i]) != i / W ||
             (i != skip && seq_d[i] !== ref_pix(i % W, i / W))) bad++;
      end
      chk({tag, "_accepted"}, 32'(acc_cnt), NPIX);
      chk({tag, "_bad_pixels"}, 32'(bad), 0);
      chk({tag, "_done_len"}, 32'(done_cnt), 1);
      chk({tag, "_done_lag"}, 32'(done_lag), 1);
   endtask

   initial begin
      bit reached;
      for (int i = 0; i < C * R; i++) mdl[i] = '0;
      reset = 1'b1;
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frameDone", 32'(frameDone), 0);
      chk("rst_pixelWrite", 32'(pixelWrite), 0);
      chk("rst_xAddr", 32'(xAddr), 0);
      chk("rst_yAddr", 32'(yAddr), 0);
      chk("rst_pixelData", 32'(pixelData), 0);
      #10 reset = 1'b0;

      // Defaults: cleared tiles over background.
      start_frame();
      chk("s1_first_x", 32'(xAddr), 0);
      chk("s1_first_y", 32'(yAddr), 0);
      chk("s1_first_write", 32'(pixelWrite), 1);
      chk("s1_first_busy", 32'(busy), 1);
      chk("s1_first_data", 32'(pixelData), 32'h5AA5);
      run_frame(1'b0, -1, -1, 0, 16'h0);
      check_frame("s1", -1);
      chk("s1_tile0_clear", px(3, 2), 0);

      // Geometry.
      write_tile(0, 16'hF800);
      write_tile(4, 16'h07E0);
      start_frame();
      run_frame(1'b0, -1, -1, 0, 16'h0);
      check_frame("s2", -1);
      chk("s2_t0_topleft", px(3, 2), 32'hF800);
      chk("s2_t0_botright", px(6, 4), 32'hF800);
      chk("s2_gap_right", px(7, 2), 32'h5AA5);
      chk("s2_left_margin", px(2, 2), 32'h5AA5);
      chk("s2_gap_below", px(3, 5), 32'h5AA5);
      chk("s2_t4_topleft", px(9, 7), 32'h07E0);
      chk("s2_t4_botright", px(12, 9), 32'h07E0);
      chk("s2_t4_leftgap", px(8, 7), 32'h5AA5);
      chk("s2_t4_rightgap", px(13, 9), 32'h5AA5);

      // Backpressure with spurious start pulses.
      start_frame();
      run_frame(1'b1, -1, -1, 0, 16'h0);
      check_frame("s3", -1);
      chk("s3_hold", 32'(hold_viol), 0);

      // Highlight.
      write_tile(8, 16'h001F);
      highlightEn = 1'b1; highlightIdx = TA'(8);
      start_frame();
      run_frame(1'b0, -1, -1, 0, 16'h0);
      check_frame("s4", -1);
      chk("s4_hl_topleft", px(15, 12), 32'hFFE0);
      chk("s4_hl_botright", px(18, 14), 32'hFFE0);
      chk("s4_t0_plain", px(3, 2), 32'hF800);
      chk("s4_right_margin", px(19, 14), 32'h5AA5);
      chk("s4_gap", px(14, 12), 32'h5AA5);

      // Out-of-range writes, then a write landing on the cycle that loads (3,2).
      highlightEn = 1'b0;
      write_tile(9, 16'hBEEF);
      write_tile(15, 16'hDEAD);
      start_frame();
      run_frame(1'b0, 2, 2, 0, 16'h0F0F);
      mdl[0] = 16'h0F0F;
      check_frame("s5", 2 * W + 3);
      chk("s5_same_cycle", px(3, 2), 32'hF800);
      chk("s5_after_write", px(4, 2), 32'h0F0F);
      chk("s5_t0_end", px(6, 4), 32'h0F0F);
      chk("s5_t8_plain", px(15, 12), 32'h001F);
      chk("s5_t4_kept", px(9, 7), 32'h07E0);

      // Asynchronous reset mid-frame.
      start_frame();
      reached = 1'b0;
      for (int cyc = 0; cyc < 1000 && !reached; cyc++) begin
         @(posedge clock); #1;
         reached = (int'(xAddr) == 10 && int'(yAddr) == 10);
      end
      chk("s6_reached", 32'(reached), 1);
      #2 reset = 1'b1;
      #1;
      chk("s6_busy", 32'(busy), 0);
      chk("s6_pixelWrite", 32'(pixelWrite), 0);
      chk("s6_xAddr", 32'(xAddr), 0);
      chk("s6_yAddr", 32'(yAddr), 0);
      chk("s6_pixelData", 32'(pixelData), 0);
      @(negedge clock) reset = 1'b0;
      for (int i = 0; i < C * R; i++) mdl[i] = '0;
      start_frame();
      chk("s6_restart_x", 32'(xAddr), 0);
      chk("s6_restart_y", 32'(yAddr), 0);
      run_frame(1'b0, -1, -1, 0, 16'h0);
      check_frame("s6", -1);
      chk("s6_tiles_cleared", px(3, 2), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
